// File: rtl/mandelbrot_render.sv
// mandelbrot_render
//
// Frame scheduler in front of the fixed-point mandelbrot engine. Walks a
// WIDTH x HEIGHT window in raster order and derives each pixel's complex
// coordinate by stepping from an origin latched at frame start. It launches one
// engine calculation per pixel and writes the returned iteration count to the
// framebuffer.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             begin a frame (only honoured while idle)
//   re_start/im_start coordinate of pixel (0,0), latched on an accepted start
//   step              per-pixel increment, latched on an accepted start
//   mb_start          one-cycle engine launch pulse
//   mb_re/mb_im       engine coordinate, stable from launch until the next step
//   mb_done/mb_iter   engine completion pulse and its iteration result
//   fb_we/fb_addr/fb_data/fb_ready  framebuffer write port with backpressure
//   busy              frame in progress
//   done              one-cycle frame-complete pulse
//   dbg_state         current FSM state (observation only)
//
// Handshakes:
//   Engine: mb_start is high for exactly one cycle. The block then waits for a
//   single-cycle mb_done, with mb_iter valid in that same cycle. mb_done is
//   ignored in every state except WAIT.
//   Framebuffer: once fb_we rises, fb_we/fb_addr/fb_data hold steady until a
//   cycle with fb_ready=1 is sampled. That cycle is the transfer, and fb_we
//   drops in the next cycle.
module mandelbrot_render #(
    parameter int FP_WIDTH = 25,
    parameter int ITERW    = 8,
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 180,
    parameter int ADDRW    = $clog2(WIDTH*HEIGHT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FP_WIDTH-1:0] re_start,
    input  logic [FP_WIDTH-1:0] im_start,
    input  logic [FP_WIDTH-1:0] step,
    output logic                mb_start,
    output logic [FP_WIDTH-1:0] mb_re,
    output logic [FP_WIDTH-1:0] mb_im,
    input  logic                mb_done,
    input  logic [ITERW-1:0]    mb_iter,
    output logic                fb_we,
    output logic [ADDRW-1:0]    fb_addr,
    output logic [ITERW-1:0]    fb_data,
    input  logic                fb_ready,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [2:0]          state_q,   state_d;
    logic [FP_WIDTH-1:0] re0_q,     re0_d;
    logic [FP_WIDTH-1:0] step_q,    step_d;
    logic [FP_WIDTH-1:0] mb_re_q,   mb_re_d;
    logic [FP_WIDTH-1:0] mb_im_q,   mb_im_d;
    logic [XW-1:0]       x_q,       x_d;
    logic [YW-1:0]       y_q,       y_d;
    logic [ADDRW-1:0]    fb_addr_q, fb_addr_d;
    logic [ITERW-1:0]    fb_data_q, fb_data_d;
    logic                fb_we_q,   fb_we_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        re0_d     = re0_q;
        step_d    = step_q;
        mb_re_d   = mb_re_q;
        mb_im_d   = mb_im_q;
        x_d       = x_q;
        y_d       = y_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = fb_we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle is spent in IDLE. A start seen in that cycle
                // is held off so it is taken on the following IDLE cycle.
                if (start && !done_q) begin
                    re0_d     = re_start;
                    step_d    = step;
                    mb_re_d   = re_start;
                    mb_im_d   = im_start;
                    x_d       = '0;
                    y_d       = '0;
                    fb_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mb_done) begin
                    fb_data_d = mb_iter;
                    fb_we_d   = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    fb_we_d = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (x_q == X_LAST) begin
                    // Each row restarts from the latched real origin, so
                    // real-axis stepping error never carries across rows.
                    x_d       = '0;
                    y_d       = y_q + YW'(1);
                    mb_re_d   = re0_q;
                    mb_im_d   = mb_im_q - step_q;
                    fb_addr_d = fb_addr_q + ADDRW'(1);
                    state_d   = S_LAUNCH;
                end else begin
                    x_d       = x_q + XW'(1);
                    mb_re_d   = mb_re_q + step_q;
                    fb_addr_d = fb_addr_q + ADDRW'(1);
                    state_d   = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            re0_q     <= '0;
            step_q    <= '0;
            mb_re_q   <= '0;
            mb_im_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            re0_q     <= re0_d;
            step_q    <= step_d;
            mb_re_q   <= mb_re_d;
            mb_im_q   <= mb_im_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // LAUNCH lasts exactly one cycle, so decoding it gives the launch pulse.
    assign mb_start  = (state_q == S_LAUNCH);
    assign mb_re     = mb_re_q;
    assign mb_im     = mb_im_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mandelbrot_render.sv
module tb_mandelbrot_render;

    localparam int FPW  = 25;
    localparam int ITW  = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX);

    // Debug encodings of the two states observed directly.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [FPW-1:0] re_start = '0;
    logic [FPW-1:0] im_start = '0;
    logic [FPW-1:0] step = '0;
    logic           mb_start;
    logic [FPW-1:0] mb_re, mb_im;
    logic           mb_done = 1'b0;
    logic [ITW-1:0] mb_iter = '0;
    logic           fb_we;
    logic [AW-1:0]  fb_addr;
    logic [ITW-1:0] fb_data;
    logic           fb_ready;
    logic           busy, done;
    logic [2:0]     dbg_state;

    mandelbrot_render #(
        .FP_WIDTH(FPW), .ITERW(ITW), .WIDTH(W), .HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .re_start(re_start), .im_start(im_start), .step(step),
        .mb_start(mb_start), .mb_re(mb_re), .mb_im(mb_im),
        .mb_done(mb_done), .mb_iter(mb_iter),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- framebuffer ready ----------------
    bit   rdy_rand = 1'b0;
    logic rdy_man  = 1'b1;
    logic rdy_rnd  = 1'b1;
    assign fb_ready = rdy_rand ? rdy_rnd : rdy_man;
    always @(posedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);

    // ---------------- monitor (negedge) ----------------
    logic [FPW-1:0] lq_re[$];
    logic [FPW-1:0] lq_im[$];
    int             lq_t[$];
    logic [AW-1:0]  wq_addr[$];
    logic [ITW-1:0] wq_data[$];
    int done_cnt = 0;
    int we_cnt = 0;
    always @(negedge clk) begin
        if (mb_start) begin
            lq_re.push_back(mb_re);
            lq_im.push_back(mb_im);
            lq_t.push_back(cyc);
        end
        if (fb_we && fb_ready) begin
            wq_addr.push_back(fb_addr);
            wq_data.push_back(fb_data);
        end
        if (fb_we) we_cnt++;
        if (done) done_cnt++;
    end

    int lr_base = 0, wr_base = 0, iss_base = 0, done_base = 0;

    // ---------------- stub engine ----------------
    // Fixed mode: answers 5 cycles after mb_start with the pixel's raster index.
    // Random mode: random latency and random iteration count.
    bit             eng_rand = 1'b0;
    int             eng_cnt = 0;
    logic [ITW-1:0] eng_it;
    logic [ITW-1:0] iss_q[$];
    always @(posedge clk) begin
        mb_done <= 1'b0;
        if (eng_cnt > 0) begin
            if (eng_cnt == 1) begin
                eng_it = eng_rand ? ITW'($urandom_range(0, 255)) : ITW'(lq_re.size() - 1 - lr_base);
                iss_q.push_back(eng_it);
                mb_done <= 1'b1;
                mb_iter <= eng_it;
            end
            eng_cnt <= eng_cnt - 1;
        end
        if (mb_start) eng_cnt <= eng_rand ? $urandom_range(1, 6) : 4;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_bases();
        lr_base   = lq_re.size();
        wr_base   = wq_addr.size();
        iss_base  = iss_q.size();
        done_base = done_cnt;
    endtask

    task automatic pulse_start(input logic [FPW-1:0] r, input logic [FPW-1:0] i, input logic [FPW-1:0] s);
        @(negedge clk);
        re_start = r; im_start = i; step = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL %s: done not seen within 3000 cycles", tag);
        end
    endtask

    // Reference: pixel p=(x,y) sits at re0 + x*step, im0 - y*step (mod 2^FPW),
    // written at address p with the iteration count issued for that pixel.
    task automatic check_frame(input string tag, input logic [FPW-1:0] r, input logic [FPW-1:0] i,
                               input logic [FPW-1:0] s, input bit fixed_iter);
        int nl, nw, x, y;
        logic [FPW-1:0] er, ei;
        logic [ITW-1:0] ed;
        nl = lq_re.size() - lr_base;
        nw = wq_addr.size() - wr_base;
        check({tag, " launches"}, 64'(nl), 64'(NPIX));
        check({tag, " writes"}, 64'(nw), 64'(NPIX));
        check({tag, " done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        for (int p = 0; p < NPIX; p++) begin
            x = p % W;
            y = p / W;
            er = r + FPW'(x) * s;
            ei = i - FPW'(y) * s;
            if (p < nl) begin
                check($sformatf("%s re p%0d", tag, p), 64'(lq_re[lr_base + p]), 64'(er));
                check($sformatf("%s im p%0d", tag, p), 64'(lq_im[lr_base + p]), 64'(ei));
            end
            if (p < nw) begin
                ed = fixed_iter ? ITW'(p) : iss_q[iss_base + p];
                check($sformatf("%s addr w%0d", tag, p), 64'(wq_addr[wr_base + p]), 64'(p));
                check($sformatf("%s data w%0d", tag, p), 64'(wq_data[wr_base + p]), 64'(ed));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mb_start"}, 64'(mb_start), 64'd0);
        check({tag, " fb_we"}, 64'(fb_we), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " mb_re"}, 64'(mb_re), 64'd0);
        check({tag, " mb_im"}, 64'(mb_im), 64'd0);
        check({tag, " fb_addr"}, 64'(fb_addr), 64'd0);
        check({tag, " fb_data"}, 64'(fb_data), 64'd0);
        check({tag, " state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [FPW-1:0] re, im, st;
        int             px, py;
        logic [FPW-1:0] exp_re, exp_im;
    } vec_t;
    vec_t tbl[6];

    localparam logic [FPW-1:0] T1_RE = 25'h1000000;   // -0x1000000
    localparam logic [FPW-1:0] T1_IM = 25'h0800000;
    localparam logic [FPW-1:0] T1_ST = 25'h0100000;
    localparam logic [FPW-1:0] T6_RE = 25'h0FFFFFF;
    localparam logic [FPW-1:0] T6_ST = 25'h0000001;

    initial begin
        logic [FPW-1:0] r, i, s;
        int c, idx, nl0, we0;

        tbl[0] = '{re: T1_RE, im: T1_IM, st: T1_ST, px: 3, py: 0, exp_re: 25'h1300000, exp_im: 25'h0800000};
        tbl[1] = '{re: T1_RE, im: T1_IM, st: T1_ST, px: 0, py: 1, exp_re: 25'h1000000, exp_im: 25'h0700000};
        tbl[2] = '{re: T1_RE, im: T1_IM, st: T1_ST, px: 2, py: 2, exp_re: 25'h1200000, exp_im: 25'h0600000};
        tbl[3] = '{re: T6_RE, im: '0, st: T6_ST, px: 1, py: 0, exp_re: 25'h1000000, exp_im: 25'h0000000};
        tbl[4] = '{re: T6_RE, im: '0, st: T6_ST, px: 0, py: 1, exp_re: 25'h0FFFFFF, exp_im: 25'h1FFFFFF};
        tbl[5] = '{re: T6_RE, im: '0, st: T6_ST, px: 3, py: 2, exp_re: 25'h1000002, exp_im: 25'h1FFFFFE};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Table frames: full-frame model plus hand-computed coordinate spots.
        for (int k = 0; k < 6; k++) begin
            set_bases();
            eng_rand = 1'b0; rdy_rand = 1'b0; rdy_man = 1'b1;
            pulse_start(tbl[k].re, tbl[k].im, tbl[k].st);
            check($sformatf("tbl%0d busy", k), 64'(busy), 64'd1);
            wait_done($sformatf("tbl%0d", k));
            check($sformatf("tbl%0d busy_at_done", k), 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
            check_frame($sformatf("tbl%0d", k), tbl[k].re, tbl[k].im, tbl[k].st, 1'b1);
            idx = lr_base + tbl[k].py * W + tbl[k].px;
            if (idx < lq_re.size()) begin
                check($sformatf("tbl%0d spot_re", k), 64'(lq_re[idx]), 64'(tbl[k].exp_re));
                check($sformatf("tbl%0d spot_im", k), 64'(lq_im[idx]), 64'(tbl[k].exp_im));
            end else begin
                n_vec++; n_bad++;
                $display("FAIL tbl%0d spot: pixel %0d never launched", k, idx - lr_base);
            end
            // LAUNCH + 5 engine cycles + WRITE + NEXT
            if (lq_t.size() >= lr_base + 2)
                check($sformatf("tbl%0d period", k), 64'(lq_t[lr_base + 1] - lq_t[lr_base]), 64'd8);
        end

        // Random frames: random origin/step, engine latency, iterations, fb_ready.
        for (int k = 0; k < 4; k++) begin
            set_bases();
            eng_rand = 1'b1; rdy_rand = 1'b1;
            r = FPW'($urandom()); i = FPW'($urandom()); s = FPW'($urandom());
            pulse_start(r, i, s);
            wait_done($sformatf("rnd%0d", k));
            repeat (3) @(negedge clk);
            check_frame($sformatf("rnd%0d", k), r, i, s, 1'b0);
        end
        eng_rand = 1'b0; rdy_rand = 1'b0; rdy_man = 1'b1;
        repeat (10) @(negedge clk);

        // Backpressure: fb_ready low for 7 cycles on pixel 5.
        set_bases();
        pulse_start(T1_RE, T1_IM, T1_ST);
        c = 0;
        while (wq_addr.size() - wr_base < 5 && c < 2000) begin @(negedge clk); c++; end
        @(posedge clk); #1 rdy_man = 1'b0;
        c = 0;
        while (!fb_we && c < 2000) begin @(negedge clk); c++; end
        check("bp fb_we_rose", 64'(fb_we), 64'd1);
        nl0 = lq_re.size();
        for (int n = 0; n < 7; n++) begin
            check($sformatf("bp hold%0d we", n), 64'(fb_we), 64'd1);
            check($sformatf("bp hold%0d addr", n), 64'(fb_addr), 64'd5);
            check($sformatf("bp hold%0d data", n), 64'(fb_data), 64'd5);
            @(negedge clk);
        end
        @(posedge clk); #1 rdy_man = 1'b1;
        @(negedge clk);
        check("bp cycle8 we", 64'(fb_we), 64'd1);
        check("bp cycle8 addr", 64'(fb_addr), 64'd5);
        @(negedge clk);
        check("bp we_dropped", 64'(fb_we), 64'd0);
        check("bp no_launch", 64'(lq_re.size() - nl0), 64'd0);
        wait_done("bp");
        repeat (3) @(negedge clk);
        check_frame("bp", T1_RE, T1_IM, T1_ST, 1'b1);

        // Start pulsed mid-frame with different coordinates is ignored.
        set_bases();
        pulse_start(T1_RE, T1_IM, T1_ST);
        c = 0;
        while (lq_re.size() - lr_base < 3 && c < 2000) begin @(negedge clk); c++; end
        @(posedge clk); #1;
        start = 1'b1; re_start = 25'h0AAAAAA; im_start = 25'h1555555; step = 25'h0033333;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done("midstart");
        repeat (3) @(negedge clk);
        check_frame("midstart", T1_RE, T1_IM, T1_ST, 1'b1);

        // Reset during WAIT of pixel 6; the stale mb_done lands after release.
        set_bases();
        pulse_start(T1_RE, T1_IM, T1_ST);
        c = 0;
        while (lq_re.size() - lr_base < 7 && c < 2000) begin @(negedge clk); c++; end
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        we0 = we_cnt;
        repeat (10) @(negedge clk);
        check("midreset stub_answered", 64'(iss_q.size() - iss_base), 64'd7);
        check("midreset no_write", 64'(we_cnt - we0), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset state", 64'(dbg_state), 64'(ST_IDLE));
        check("midreset fb_addr", 64'(fb_addr), 64'd0);
        set_bases();
        pulse_start(T1_RE, T1_IM, T1_ST);
        wait_done("restart");
        repeat (3) @(negedge clk);
        check_frame("restart", T1_RE, T1_IM, T1_ST, 1'b1);

        // start held high across done: accepted only on the IDLE cycle after done.
        @(negedge clk);
        re_start = T6_RE; im_start = '0; step = T6_ST; start = 1'b1;
        wait_done("overlap1");
        check("overlap done_busy", 64'(busy), 64'd0);
        check("overlap done_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        check("overlap gap_busy", 64'(busy), 64'd0);
        check("overlap gap_state", 64'(dbg_state), 64'(ST_IDLE));
        check("overlap gap_done", 64'(done), 64'd0);
        set_bases();
        @(negedge clk);
        check("overlap accept_busy", 64'(busy), 64'd1);
        check("overlap accept_state", 64'(dbg_state), 64'(ST_LAUNCH));
        start = 1'b0;
        wait_done("overlap2");
        repeat (3) @(negedge clk);
        check_frame("overlap2", T6_RE, 25'h0, T6_ST, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
